sec_check_encoder: RTL and testbench

- Streaming single-error-correcting (SEC) check-bit generator: 32-bit data word in, 40-bit codeword out (data plus 8 check bits).
- Transmit-side counterpart of the c499 32-bit SEC corrector. Its check bits feed the corrector's IC0..IC7 inputs, with R (N137) tied high; an uncorrupted word then yields a zero syndrome.
- 2-stage valid/ready pipeline.
- Has a one-shot single-bit error injector so benches can exercise the corrector's correction path.

---
 rtl/sec_check_encoder_if.sv | 29 ++
 rtl/sec_check_encoder.sv | 167 ++++++++++++++++
 tb/tb_sec_check_encoder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sec_check_encoder_if.sv
// Streaming bus for the SEC check-bit encoder: a 32-bit data word enters,
// and a 40-bit codeword (data plus 8 check bits) leaves. The master side is
// the one that offers data and accepts codewords.
interface sec_check_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_cw;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_cw
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_cw
  );
endinterface

// File: rtl/sec_check_encoder.sv
// Streaming single-error-correcting check-bit generator, the transmit-side
// partner of the c499 32-bit SEC corrector. Each accepted 32-bit word leaves
// two cycles later as a 40-bit codeword {C7..C0, D31..D0}. A one-shot
// injector can flip a single codeword bit of the next accepted word so the
// corrector's repair path can be exercised.
module sec_check_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sec_check_encoder_if.slave bus,
  input  logic             inj_arm,
  input  logic [5:0]       inj_pos,
  output logic             inj_err,
  output logic             inj_pending,
  output logic [CNT_W-1:0] word_cnt
);

  // Data-bit membership of each check bit; bit i of entry k set means
  // D[i] is folded into C[k]. Each group has 12 members, so an all-ones
  // word produces an all-zero check byte.
  localparam logic [31:0] COL_C0 = 32'h00FF_1111;
  localparam logic [31:0] COL_C1 = 32'hFF00_2222;
  localparam logic [31:0] COL_C2 = 32'h0F0F_4444;
  localparam logic [31:0] COL_C3 = 32'hF0F0_8888;
  localparam logic [31:0] COL_C4 = 32'h1111_00FF;
  localparam logic [31:0] COL_C5 = 32'h2222_FF00;
  localparam logic [31:0] COL_C6 = 32'h4444_0F0F;
  localparam logic [31:0] COL_C7 = 32'h8888_F0F0;

  localparam logic [7:0][31:0] CHK_COLS = {
    COL_C7, COL_C6, COL_C5, COL_C4, COL_C3, COL_C2, COL_C1, COL_C0
  };

  // Highest legal codeword bit index for injection.
  localparam logic [5:0] CW_MSB = 6'd39;

  // Even parity over each check group.
  function automatic logic [7:0] calc_check(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[k] = ^(d & CHK_COLS[k]);
    end
    return c;
  endfunction

  // Stage 1 holds the raw word, its check byte and the flip mask.
  logic        s1_valid;
  logic [31:0] s1_data;
  logic [7:0]  s1_chk;
  logic [39:0] s1_mask;

  // Stage 2 is the output register itself.
  logic        s2_valid;
  logic [39:0] s2_cw;

  // Injector state.
  logic [5:0]  inj_pos_q;
  logic        inj_pending_q;
  logic        inj_err_q;

  logic [CNT_W-1:0] word_cnt_q;

  // Handshake and datapath helpers.
  logic        s2_adv;
  logic        s1_adv;
  logic        in_fire;
  logic [7:0]  in_chk;
  logic [39:0] in_mask;
  logic        arm_ok;
  logic        arm_bad;

  // Stall propagation runs back from the sink; in_valid never feeds in_ready.
  always_comb begin
    // NOTE: every combinational output is given a default before any
    // condition so that no path leaves it unassigned and infers a latch.
    s2_adv  = 1'b0;
    s1_adv  = 1'b0;
    in_fire = 1'b0;
    s2_adv  = !s2_valid || bus.out_ready;
    s1_adv  = !s1_valid || s2_adv;
    in_fire = bus.in_valid && s1_adv;
  end

  // Check byte and the flip mask for the word arriving this cycle.
  always_comb begin
    in_chk  = calc_check(bus.in_data);
    in_mask = '0;
    if (inj_pending_q) begin
      in_mask = 40'(1) << inj_pos_q;
    end
  end

  // Classify an arm request by whether it names a real codeword bit.
  always_comb begin
    arm_ok  = inj_arm && (inj_pos <= CW_MSB);
    arm_bad = inj_arm && (inj_pos >  CW_MSB);
  end

  // Stage 1 register: captures an accepted word, or empties when drained.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // in the design samples the values present before the clock edge.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_chk   <= '0;
      s1_mask  <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_chk  <= in_chk;
        s1_mask <= in_mask;
      end
    end
  end

  // Stage 2 register: applies the flip mask and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_cw    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cw <= {s1_chk, s1_data} ^ s1_mask;
      end
    end
  end

  // Injector: a fresh arm wins over consumption, so an arm that coincides
  // with an input transfer targets the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_pending_q <= 1'b0;
      inj_pos_q     <= '0;
      inj_err_q     <= 1'b0;
    end else begin
      inj_err_q <= arm_bad;
      if (arm_ok) begin
        inj_pending_q <= 1'b1;
        inj_pos_q     <= inj_pos;
      end else if (in_fire) begin
        inj_pending_q <= 1'b0;
      end
    end
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (in_fire) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_cw    = s2_cw;
  assign inj_pending   = inj_pending_q;
  assign inj_err       = inj_err_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_sec_check_encoder.sv
// Self-checking bench for sec_check_encoder: directed cases for reset,
// latency, walking ones and injection, then randomized streaming with a
// toggling sink, a mid-flight reset and a counter wrap.
module tb_sec_check_encoder;

  logic        clk;
  logic        rst;
  logic        inj_arm;
  logic [5:0]  inj_pos;
  logic        inj_err;
  logic        inj_pending;
  logic [15:0] word_cnt;

  sec_check_encoder_if bus ();

  sec_check_encoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inj_arm     (inj_arm),
    .inj_pos     (inj_pos),
    .inj_err     (inj_err),
    .inj_pending (inj_pending),
    .word_cnt    (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check-bit groups written out as data-bit index lists.
  int grp [8][12] = '{
    '{0, 4, 8, 12, 16, 17, 18, 19, 20, 21, 22, 23},
    '{1, 5, 9, 13, 24, 25, 26, 27, 28, 29, 30, 31},
    '{2, 6, 10, 14, 16, 17, 18, 19, 24, 25, 26, 27},
    '{3, 7, 11, 15, 20, 21, 22, 23, 28, 29, 30, 31},
    '{0, 1, 2, 3, 4, 5, 6, 7, 16, 20, 24, 28},
    '{8, 9, 10, 11, 12, 13, 14, 15, 17, 21, 25, 29},
    '{0, 1, 2, 3, 8, 9, 10, 11, 18, 22, 26, 30},
    '{4, 5, 6, 7, 12, 13, 14, 15, 19, 23, 27, 31}
  };

  int n_vec;
  int n_err;

  // Reference model state.
  logic [39:0] q[$];
  logic        m_pend;
  logic [5:0]  m_pos;
  logic        m_err;
  logic [15:0] m_cnt;
  logic        prev_stall;
  logic [39:0] prev_cw;
  logic [39:0] last_out;
  logic        fired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 12; j++)
        c[i] = c[i] ^ d[grp[i][j]];
    return c;
  endfunction

  // One clock: observe and update the model at the falling edge, then
  // return just after the rising edge so the caller can change inputs.
  task automatic step();
    logic [39:0] mask;
    logic [39:0] exp_cw;
    @(negedge clk);
    fired = 1'b0;
    if (rst) begin
      q.delete();
      m_pend     = 1'b0;
      m_err      = 1'b0;
      m_cnt      = '0;
      prev_stall = 1'b0;
    end else begin
      check("inj_pending", 64'(inj_pending), 64'(m_pend));
      check("inj_err", 64'(inj_err), 64'(m_err));
      check("word_cnt", 64'(word_cnt), 64'(m_cnt));
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_cw", 64'(bus.out_cw), 64'(prev_cw));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(bus.out_cw), 64'hDEAD);
        end else begin
          exp_cw = q.pop_front();
          check("out_cw", 64'(bus.out_cw), 64'(exp_cw));
          last_out = bus.out_cw;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_cw    = bus.out_cw;
      if (bus.in_valid && bus.in_ready) begin
        mask = m_pend ? (40'd1 << m_pos) : 40'd0;
        q.push_back({ref_check(bus.in_data), bus.in_data} ^ mask);
        m_pend = 1'b0;
        m_cnt  = m_cnt + 16'd1;
        fired  = 1'b1;
      end
      m_err = 1'b0;
      if (inj_arm) begin
        if (inj_pos > 6'd39) begin
          m_err = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_pos  = inj_pos;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    fired = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (fired) break;
    end
    if (!fired) check("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      step();
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic arm(input logic [5:0] pos);
    inj_arm = 1'b1;
    inj_pos = pos;
    step();
    inj_arm = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_pend = 1'b0;
    m_pos = '0;
    m_err = 1'b0;
    m_cnt = '0;
    prev_stall = 1'b0;
    prev_cw = '0;
    last_out = '0;
    rst = 1'b1;
    inj_arm = 1'b0;
    inj_pos = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_cw", 64'(bus.out_cw), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_inj_pending", 64'(inj_pending), 64'd0);

    // Two-cycle latency on an all-zero word.
    bus.out_ready = 1'b1;
    send(32'h0000_0000);
    check("lat1_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("lat2_valid", 64'(bus.out_valid), 64'd1);
    check("lat2_cw", 64'(bus.out_cw), 64'h00_0000_0000);
    drain();

    send(32'hFFFF_FFFF);
    drain();
    check("all_ones_cw", 64'(last_out), 64'h00_FFFF_FFFF);

    // Walking one across the data bits.
    for (int i = 0; i < 32; i++) begin
      send(32'd1 << i);
      drain();
      if (i == 0)  check("walk_d0", 64'(last_out[39:32]), 64'h51);
      if (i == 17) check("walk_d17", 64'(last_out[39:32]), 64'h25);
      if (i == 31) check("walk_d31", 64'(last_out[39:32]), 64'h8A);
    end

    // Injection at bit 5, then an unflipped follower.
    arm(6'd5);
    check("inj_armed", 64'(inj_pending), 64'd1);
    send(32'h0000_0000);
    check("inj_consumed", 64'(inj_pending), 64'd0);
    drain();
    check("inj5_cw", 64'(last_out), 64'h00_0000_0020);
    send(32'h0000_0000);
    drain();
    check("inj_follow_cw", 64'(last_out), 64'h00_0000_0000);

    // Injection at the top codeword bit.
    arm(6'd39);
    send(32'h0000_0000);
    drain();
    check("inj39_cw", 64'(last_out), 64'h80_0000_0000);

    // Out-of-range position: error pulse, nothing armed.
    arm(6'd45);
    check("inj_err_pulse", 64'(inj_err), 64'd1);
    check("inj_err_nopend", 64'(inj_pending), 64'd0);
    step();
    check("inj_err_clear", 64'(inj_err), 64'd0);
    send(32'h0000_0000);
    drain();
    check("inj_bad_cw", 64'(last_out), 64'h00_0000_0000);

    // Re-arm replaces, and an arm alongside a transfer targets the next word.
    arm(6'd3);
    arm(6'd9);
    inj_arm = 1'b1;
    inj_pos = 6'd7;
    send(32'h1234_5678);
    inj_arm = 1'b0;
    send(32'h9ABC_DEF0);
    drain();
    inj_arm = 1'b1;
    inj_pos = 6'd33;
    send(32'h0F0F_0F0F);
    inj_arm = 1'b0;
    send(32'h0F0F_0F0F);
    drain();

    // Random streaming with a toggling sink and sporadic injections.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = $urandom;
      bus.out_ready = $urandom % 2;
      inj_arm       = ($urandom % 16) == 0;
      inj_pos       = 6'($urandom % 48);
      step();
    end
    inj_arm = 1'b0;
    drain();

    // Reset with two words in flight.
    bus.out_ready = 1'b0;
    send(32'hAAAA_5555);
    send(32'h5555_AAAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("midrst_no_stale", 64'(bus.out_valid), 64'd0);

    // Run the counter up to its top value, then across the wrap.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      if (m_cnt == 16'hFFFF) break;
      bus.in_data = $urandom;
      step();
    end
    check("cnt_top", 64'(word_cnt), 64'hFFFF);
    bus.in_data = $urandom;
    step();
    check("cnt_wrap0", 64'(word_cnt), 64'h0000);
    bus.in_data = $urandom;
    step();
    check("cnt_wrap1", 64'(word_cnt), 64'h0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
